pll_reconfig_seq: RTL and testbench
===================================

# pll_reconfig_seq

Parametrised PLL bring-up and dynamic-reconfiguration sequencer for the CCC clock block. It powers the PLL up from reset, writes new output-divider values through the PLL DRI port on request, and qualifies lock before enabling outputs. It also monitors for loss of lock, gating the outputs and counting events. It sits in the fabric clock domain beside the CCC and drives the PLL's POWERDOWN_N, OUTn_EN and DRI write pins.

## Interface
- NUM_OUT, 3: PLL outputs managed (1–4).
- DIV_W, 7: divider value width.
- DIV_ADDR_BASE, 8'h10: DRI address of OUT0 divider; channel n at base+n.
- PD_CYCLES, 16: cycles POWERDOWN_N is held low per power cycle (≥1).
- LOCK_STABLE, 32: consecutive synchronised-lock cycles required to qualify lock (≥1).
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before timeout.
- MAX_RETRY, 2: power-cycle retries after a timeout before ERROR.
- CNT_W, 8: loss-of-lock counter width.

Ports:
- CLK  in  1  fabric clock.
- RESET  in  1  asynchronous, active-high reset.
- CFG_REQ  in  1  reconfiguration request, level, sampled only when accepted.
- CFG_DIV  in  NUM_OUT*DIV_W  new divider values, channel n at [n*DIV_W +: DIV_W].
- CFG_MASK  in  NUM_OUT  channels to rewrite.
- CFG_ACK  out  1  one-cycle pulse: request completed, lock qualified.
- CFG_ERR  out  1  sticky: retries exhausted.
- BUSY  out  1  high in every state except RUN and ERROR.
- PLL_LOCK  in  1  raw PLL lock, asynchronous to CLK.
- PLL_POWERDOWN_N  out  1  to PLL POWERDOWN_N.
- OUT_EN  out  NUM_OUT  to PLL OUTn_EN.
- DRI_WR  out  1  DRI write strobe, held until DRI_ACK.
- DRI_ADDR  out  8  DRI write address.
- DRI_WDATA  out  DIV_W  DRI write data.
- DRI_ACK  in  1  DRI write accepted.
- LOCKED  out  1  qualified lock.
- LOL_COUNT  out  CNT_W  loss-of-lock events, saturating.
- LOL_CLR  in  1  clear LOL_COUNT.

## Operation
- PLL_LOCK passes through a 2-flop synchroniser (lock_s). All lock decisions use lock_s.
- States: PD, WRITE, RELEASE, WAIT_LOCK, RUN, ERROR.
- Reset values:
  - State is PD.
  - PLL_POWERDOWN_N=0, OUT_EN=0, DRI_WR=0, DRI_ADDR=0, DRI_WDATA=0.
  - CFG_ACK=0, CFG_ERR=0, LOCKED=0, BUSY=1, LOL_COUNT=0.
  - Retry count=0; pending-ack flag=0.
- PD:
  - POWERDOWN_N=0, OUT_EN=0, LOCKED=0.
  - After PD_CYCLES cycles: go to WRITE if any latched mask bits remain unwritten, else RELEASE.
  - After reset the latched mask is 0, so bring-up skips WRITE.
- WRITE:
  - Channels are written in ascending index order; masked-off channels are skipped with no idle cycle.
  - Per write: DRI_WR=1 with DRI_ADDR=DIV_ADDR_BASE+n and DRI_WDATA=latched div[n].
  - DRI_WR, DRI_ADDR and DRI_WDATA are held stable until DRI_ACK is sampled high. DRI_WR then drops for at least one cycle.
  - After the last channel: go to RELEASE.
- RELEASE: POWERDOWN_N=1 for one cycle, then WAIT_LOCK with the timeout and stable counters cleared.
- WAIT_LOCK:
  - Stable counter increments while lock_s=1 and clears on lock_s=0.
  - Stable counter reaching LOCK_STABLE goes to RUN; this takes precedence over timeout in the same cycle.
  - Timeout counter reaching LOCK_TIMEOUT: if retry<MAX_RETRY, increment retry and go to PD (latched mask kept, divider writes repeated); else go to ERROR.
- Entering RUN:
  - LOCKED=1, OUT_EN all ones, retry cleared.
  - If pending-ack is set: CFG_ACK pulses, pending-ack clears, CFG_ERR clears.
- RUN:
  - lock_s=0: LOCKED=0 and OUT_EN=0 next cycle, LOL_COUNT+1 (saturating at all ones), go to WAIT_LOCK without power-cycling. Counters clear; retry rules apply as in WAIT_LOCK.
  - CFG_REQ=1 with CFG_MASK≠0: latch CFG_DIV and CFG_MASK, set pending-ack, go to PD.
  - CFG_REQ=1 with CFG_MASK=0: CFG_ACK pulses next cycle; state unchanged.
- ERROR:
  - CFG_ERR=1, POWERDOWN_N=0, OUT_EN=0, LOCKED=0.
  - CFG_REQ=1 (any mask): latch inputs, clear retry, set pending-ack, go to PD. CFG_ERR stays 1 until the next successful CFG_ACK.
- CFG_REQ is ignored while BUSY.
- LOL_CLR clears LOL_COUNT to 0. When LOL_CLR coincides with an increment, the result is 1.
- RESET asserted mid-sequence returns every output to its reset value immediately, with no DRI handshake completion. A DRI write cut off by reset is not re-issued; the next request rewrites all of its masked channels.

## Timing
- All outputs are registered.
- Lock detection latency: 2 synchroniser cycles + 1.
- Request to first DRI_WR: PD_CYCLES+1 cycles.
- Each DRI write takes (ACK delay + 1) cycles, plus 1 gap cycle before the next write.
- Best-case request to CFG_ACK: PD_CYCLES + writes + 1 + 2 + LOCK_STABLE + 1 cycles.
- CFG_ACK is exactly 1 cycle wide.

## Test plan
Parameters: NUM_OUT=3, PD_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, MAX_RETRY=2.
- Reset release, PLL_LOCK rising 10 cycles after POWERDOWN_N=1 -> POWERDOWN_N low for 4 cycles, no DRI_WR, LOCKED and OUT_EN=3'b111 together, no CFG_ACK.
- In RUN, CFG_REQ with CFG_MASK=3'b101, div={7'd4,7'd9,7'd2}, DRI_ACK 2 cycles after WR -> exactly 2 writes: (0x10,2) then (0x12,4); CFG_ACK once after relock.
- CFG_REQ with CFG_MASK=0 in RUN -> CFG_ACK next cycle, POWERDOWN_N stays 1.
- PLL_LOCK held low after a request -> 3 PD episodes (initial + 2 retries), then ERROR with CFG_ERR=1. A new CFG_REQ with lock available -> CFG_ACK and CFG_ERR cleared.
- In RUN, 3 single PLL_LOCK drops lasting 20 cycles -> LOL_COUNT=3, OUT_EN=0 during each drop, no POWERDOWN; LOL_CLR coinciding with a 4th drop -> LOL_COUNT=1.
- RESET asserted while DRI_WR is held -> DRI_WR=0 and POWERDOWN_N=0 immediately; bring-up restarts with no writes.

Source files
------------

// File: rtl/pll_reconfig_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : pll_reconfig_seq
//  Brief    : PLL bring-up and dynamic output-divider reconfiguration
//             sequencer. Power-cycles the PLL, rewrites dividers over the
//             DRI port, qualifies lock before enabling outputs and counts
//             loss-of-lock events.
//  Revision : 1.0 - initial release
// ============================================================================
module pll_reconfig_seq #(
    parameter int unsigned NUM_OUT       = 3,
    parameter int unsigned DIV_W         = 7,
    parameter logic [7:0]  DIV_ADDR_BASE = 8'h10,
    parameter int unsigned PD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE   = 32,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned MAX_RETRY     = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cfg_req_i,
    input  logic [NUM_OUT*DIV_W-1:0] cfg_div_i,
    input  logic [NUM_OUT-1:0]       cfg_mask_i,
    output logic                     cfg_ack_o,
    output logic                     cfg_err_o,
    output logic                     busy_o,
    input  logic                     pll_lock_i,
    output logic                     pll_powerdown_n_o,
    output logic [NUM_OUT-1:0]       out_en_o,
    output logic                     dri_wr_o,
    output logic [7:0]               dri_addr_o,
    output logic [DIV_W-1:0]         dri_wdata_o,
    input  logic                     dri_ack_i,
    output logic                     locked_o,
    output logic [CNT_W-1:0]         lol_count_o,
    input  logic                     lol_clr_i
);

    localparam int unsigned CH_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int unsigned PD_W  = $clog2(PD_CYCLES + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_PD        = 3'd0,
        S_WRITE     = 3'd1,
        S_RELEASE   = 3'd2,
        S_WAIT_LOCK = 3'd3,
        S_RUN       = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    state_t                     state_q;
    logic [1:0]                 sync_q;
    logic                       lock_s;
    logic [PD_W-1:0]            pd_cnt_q;
    logic [STB_W-1:0]           stab_q;
    logic [TO_W-1:0]            to_q;
    logic [RTY_W-1:0]           retry_q;
    logic                       pend_q;
    logic [NUM_OUT*DIV_W-1:0]   cfg_div_q;
    logic [NUM_OUT-1:0]         cfg_mask_q;
    logic [NUM_OUT-1:0]         wr_mask_q;
    logic [CH_W-1:0]            cur_ch_q;

    logic                       pwrdn_n_q;
    logic [NUM_OUT-1:0]         out_en_q;
    logic                       dri_wr_q;
    logic [7:0]                 dri_addr_q;
    logic [DIV_W-1:0]           dri_wdata_q;
    logic                       ack_q;
    logic                       err_q;
    logic                       locked_q;
    logic                       busy_q;
    logic [CNT_W-1:0]           lol_q;

    logic [CH_W-1:0]            nxt_ch_d;
    logic [DIV_W-1:0]           nxt_div_d;
    logic [NUM_OUT-1:0]         wr_mask_left_d;
    logic [STB_W-1:0]           stab_inc_d;
    logic [TO_W-1:0]            to_inc_d;
    logic                       stable_d;
    logic                       timeout_d;
    logic                       lol_inc_d;

    assign lock_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock_i};
        end
    end

    // Lowest pending channel, its divider value and lock-qualification terms.
    always_comb begin
        nxt_ch_d = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (wr_mask_q[i]) begin
                nxt_ch_d = CH_W'(i);
            end
        end
        nxt_div_d = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (nxt_ch_d == CH_W'(i)) begin
                nxt_div_d = cfg_div_q[i*DIV_W +: DIV_W];
            end
        end
        wr_mask_left_d           = wr_mask_q;
        wr_mask_left_d[cur_ch_q] = 1'b0;
        stab_inc_d = stab_q + 1'b1;
        to_inc_d   = to_q + 1'b1;
        stable_d   = lock_s && (stab_inc_d == STB_W'(LOCK_STABLE));
        timeout_d  = (to_inc_d == TO_W'(LOCK_TIMEOUT));
        lol_inc_d  = (state_q == S_RUN) && !lock_s;
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_PD;
            pd_cnt_q    <= '0;
            stab_q      <= '0;
            to_q        <= '0;
            retry_q     <= '0;
            pend_q      <= 1'b0;
            cfg_div_q   <= '0;
            cfg_mask_q  <= '0;
            wr_mask_q   <= '0;
            cur_ch_q    <= '0;
            pwrdn_n_q   <= 1'b0;
            out_en_q    <= '0;
            dri_wr_q    <= 1'b0;
            dri_addr_q  <= '0;
            dri_wdata_q <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_PD: begin
                    if (pd_cnt_q == PD_W'(PD_CYCLES - 1)) begin
                        pd_cnt_q <= '0;
                        if (wr_mask_q != '0) begin
                            state_q     <= S_WRITE;
                            dri_wr_q    <= 1'b1;
                            dri_addr_q  <= DIV_ADDR_BASE + 8'(nxt_ch_d);
                            dri_wdata_q <= nxt_div_d;
                            cur_ch_q    <= nxt_ch_d;
                        end else begin
                            state_q   <= S_RELEASE;
                            pwrdn_n_q <= 1'b1;
                        end
                    end else begin
                        pd_cnt_q <= pd_cnt_q + 1'b1;
                    end
                end

                S_WRITE: begin
                    if (dri_wr_q) begin
                        // Hold the strobe and payload until the DRI accepts.
                        if (dri_ack_i) begin
                            dri_wr_q  <= 1'b0;
                            wr_mask_q <= wr_mask_left_d;
                            if (wr_mask_left_d == '0) begin
                                state_q   <= S_RELEASE;
                                pwrdn_n_q <= 1'b1;
                            end
                        end
                    end else begin
                        // Gap cycle done: issue the next pending channel.
                        dri_wr_q    <= 1'b1;
                        dri_addr_q  <= DIV_ADDR_BASE + 8'(nxt_ch_d);
                        dri_wdata_q <= nxt_div_d;
                        cur_ch_q    <= nxt_ch_d;
                    end
                end

                S_RELEASE: begin
                    state_q <= S_WAIT_LOCK;
                    stab_q  <= '0;
                    to_q    <= '0;
                end

                S_WAIT_LOCK: begin
                    stab_q <= lock_s ? stab_inc_d : '0;
                    to_q   <= to_inc_d;
                    if (stable_d) begin
                        state_q  <= S_RUN;
                        locked_q <= 1'b1;
                        out_en_q <= '1;
                        retry_q  <= '0;
                        busy_q   <= 1'b0;
                        if (pend_q) begin
                            ack_q  <= 1'b1;
                            pend_q <= 1'b0;
                            err_q  <= 1'b0;
                        end
                    end else if (timeout_d) begin
                        if (retry_q < RTY_W'(MAX_RETRY)) begin
                            // Power-cycle again, repeating the latched writes.
                            retry_q   <= retry_q + 1'b1;
                            state_q   <= S_PD;
                            pd_cnt_q  <= '0;
                            wr_mask_q <= cfg_mask_q;
                            pwrdn_n_q <= 1'b0;
                            out_en_q  <= '0;
                            locked_q  <= 1'b0;
                        end else begin
                            state_q   <= S_ERROR;
                            err_q     <= 1'b1;
                            pwrdn_n_q <= 1'b0;
                            out_en_q  <= '0;
                            locked_q  <= 1'b0;
                            busy_q    <= 1'b0;
                        end
                    end
                end

                S_RUN: begin
                    if (!lock_s) begin
                        // Loss of lock: gate outputs, requalify without power-cycling.
                        state_q  <= S_WAIT_LOCK;
                        locked_q <= 1'b0;
                        out_en_q <= '0;
                        stab_q   <= '0;
                        to_q     <= '0;
                        busy_q   <= 1'b1;
                    end else if (cfg_req_i) begin
                        if (cfg_mask_i != '0) begin
                            cfg_div_q  <= cfg_div_i;
                            cfg_mask_q <= cfg_mask_i;
                            wr_mask_q  <= cfg_mask_i;
                            pend_q     <= 1'b1;
                            state_q    <= S_PD;
                            pd_cnt_q   <= '0;
                            pwrdn_n_q  <= 1'b0;
                            out_en_q   <= '0;
                            locked_q   <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            ack_q <= 1'b1;
                        end
                    end
                end

                S_ERROR: begin
                    if (cfg_req_i) begin
                        cfg_div_q  <= cfg_div_i;
                        cfg_mask_q <= cfg_mask_i;
                        wr_mask_q  <= cfg_mask_i;
                        retry_q    <= '0;
                        pend_q     <= 1'b1;
                        state_q    <= S_PD;
                        pd_cnt_q   <= '0;
                        busy_q     <= 1'b1;
                    end
                end

                default: begin
                    state_q   <= S_PD;
                    pd_cnt_q  <= '0;
                    pwrdn_n_q <= 1'b0;
                    out_en_q  <= '0;
                    locked_q  <= 1'b0;
                    dri_wr_q  <= 1'b0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    // Saturating loss-of-lock counter; a clear coinciding with an event leaves 1.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lol_q <= '0;
        end else if (lol_clr_i) begin
            lol_q <= lol_inc_d ? CNT_W'(1) : '0;
        end else if (lol_inc_d && (lol_q != '1)) begin
            lol_q <= lol_q + 1'b1;
        end
    end

    assign cfg_ack_o         = ack_q;
    assign cfg_err_o         = err_q;
    assign busy_o            = busy_q;
    assign pll_powerdown_n_o = pwrdn_n_q;
    assign out_en_o          = out_en_q;
    assign dri_wr_o          = dri_wr_q;
    assign dri_addr_o        = dri_addr_q;
    assign dri_wdata_o       = dri_wdata_q;
    assign locked_o          = locked_q;
    assign lol_count_o       = lol_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pll_reconfig_seq
//  Brief    : Directed self-checking bench for pll_reconfig_seq with a
//             behavioural PLL lock model and a DRI write responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_seq;

    localparam int NUM_OUT = 3;
    localparam int DIV_W   = 7;
    localparam int CNT_W   = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cfg_req;
    logic [NUM_OUT*DIV_W-1:0] cfg_div;
    logic [NUM_OUT-1:0]       cfg_mask;
    logic                     cfg_ack;
    logic                     cfg_err;
    logic                     busy;
    logic                     pll_lock;
    logic                     pwrdn;
    logic [NUM_OUT-1:0]       out_en;
    logic                     dri_wr;
    logic [7:0]               dri_addr;
    logic [DIV_W-1:0]         dri_wdata;
    logic                     dri_ack;
    logic                     locked;
    logic [CNT_W-1:0]         lol_count;
    logic                     lol_clr;

    // Bench controls for the PLL and DRI models.
    logic lock_avail;
    logic force_drop;
    logic hold_ack;

    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt  = 0;
    int ack_wide = 0;
    int pd_eps   = 0;
    int stab_err = 0;
    logic [7:0]       wr_addr[$];
    logic [DIV_W-1:0] wr_data[$];

    pll_reconfig_seq #(
        .NUM_OUT      (3),
        .DIV_W        (7),
        .DIV_ADDR_BASE(8'h10),
        .PD_CYCLES    (4),
        .LOCK_STABLE  (8),
        .LOCK_TIMEOUT (64),
        .MAX_RETRY    (2),
        .CNT_W        (8)
    ) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .cfg_req_i        (cfg_req),
        .cfg_div_i        (cfg_div),
        .cfg_mask_i       (cfg_mask),
        .cfg_ack_o        (cfg_ack),
        .cfg_err_o        (cfg_err),
        .busy_o           (busy),
        .pll_lock_i       (pll_lock),
        .pll_powerdown_n_o(pwrdn),
        .out_en_o         (out_en),
        .dri_wr_o         (dri_wr),
        .dri_addr_o       (dri_addr),
        .dri_wdata_o      (dri_wdata),
        .dri_ack_i        (dri_ack),
        .locked_o         (locked),
        .lol_count_o      (lol_count),
        .lol_clr_i        (lol_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // PLL model: lock rises 10 cycles after power-up, drops on power-down or forced drop.
    initial begin : pll_model
        int up_cnt;
        up_cnt   = 0;
        pll_lock = 1'b0;
        forever begin
            @(negedge clk);
            if (!pwrdn || !lock_avail) begin
                pll_lock = 1'b0;
                up_cnt   = 0;
            end else if (force_drop) begin
                pll_lock = 1'b0;
            end else if (up_cnt >= 10) begin
                pll_lock = 1'b1;
            end else begin
                up_cnt++;
            end
        end
    end

    // DRI responder: acknowledges 2 cycles after the strobe, logs writes, checks stability.
    initial begin : dri_model
        int age;
        logic [7:0]       a0;
        logic [DIV_W-1:0] d0;
        age = 0; a0 = '0; d0 = '0;
        dri_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || dri_ack) begin
                dri_ack = 1'b0;
                age     = 0;
            end else if (dri_wr && !hold_ack) begin
                if (age == 0) begin
                    a0 = dri_addr;
                    d0 = dri_wdata;
                end else if (dri_addr != a0 || dri_wdata != d0) begin
                    stab_err++;
                end
                age++;
                if (age == 2) begin
                    dri_ack = 1'b1;
                    wr_addr.push_back(dri_addr);
                    wr_data.push_back(dri_wdata);
                end
            end
        end
    end

    // Event monitor: ack pulses, ack width, power-down episodes while busy.
    initial begin : monitor
        logic prev_ack;
        logic prev_pd;
        prev_ack = 1'b0;
        prev_pd  = 1'b0;
        forever begin
            @(negedge clk);
            if (cfg_ack) begin
                ack_cnt++;
                if (prev_ack) ack_wide++;
            end
            prev_ack = cfg_ack;
            if (prev_pd && !pwrdn && busy) pd_eps++;
            prev_pd = pwrdn;
        end
    end

    // Watchdog keeps the run bounded even if the DUT stalls.
    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int cnt;
        int a0;
        int e0;
        rst = 1'b1; cfg_req = 1'b0; cfg_div = '0; cfg_mask = '0; lol_clr = 1'b0;
        lock_avail = 1'b1; force_drop = 1'b0; hold_ack = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst_pwrdn",  pwrdn, 0);
        check_eq("rst_out_en", out_en, 0);
        check_eq("rst_dri_wr", dri_wr, 0);
        check_eq("rst_busy",   busy, 1);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_lol",    lol_count, 0);
        check_eq("rst_ack",    cfg_ack, 0);
        check_eq("rst_err",    cfg_err, 0);

        // Bring-up: 4 power-down cycles, no writes, outputs enabled with LOCKED
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && !pwrdn; i++) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("bringup_pd_cycles", cnt, 4);
        for (int i = 0; i < 200 && !locked; i++) @(negedge clk);
        check_eq("bringup_locked", locked, 1);
        check_eq("bringup_out_en", out_en, 3'b111);
        check_eq("bringup_no_wr",  wr_addr.size(), 0);
        check_eq("bringup_no_ack", ack_cnt, 0);
        check_eq("bringup_busy",   busy, 0);

        // Masked reconfiguration: channels 0 and 2 only
        repeat (3) @(negedge clk);
        wr_addr.delete(); wr_data.delete();
        a0 = ack_cnt;
        cfg_div = {7'd4, 7'd9, 7'd2}; cfg_mask = 3'b101; cfg_req = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
        for (int i = 0; i < 300 && ack_cnt == a0; i++) @(negedge clk);
        @(negedge clk);
        check_eq("cfg_ack_once",  ack_cnt - a0, 1);
        check_eq("cfg_wr_count",  wr_addr.size(), 2);
        check_eq("cfg_wr0_addr",  wr_addr[0], 8'h10);
        check_eq("cfg_wr0_data",  wr_data[0], 2);
        check_eq("cfg_wr1_addr",  wr_addr[1], 8'h12);
        check_eq("cfg_wr1_data",  wr_data[1], 4);
        check_eq("cfg_locked",    locked, 1);
        check_eq("cfg_out_en",    out_en, 3'b111);
        check_eq("cfg_no_lol",    lol_count, 0);
        check_eq("cfg_wr_stable", stab_err, 0);
        check_eq("cfg_ack_width", ack_wide, 0);

        // Empty-mask request in RUN: immediate ack, no power cycle
        repeat (3) @(negedge clk);
        cfg_mask = 3'b000; cfg_req = 1'b1;
        @(negedge clk);
        check_eq("nomask_ack",   cfg_ack, 1);
        check_eq("nomask_pwrdn", pwrdn, 1);
        check_eq("nomask_busy",  busy, 0);
        cfg_req = 1'b0;
        @(negedge clk);
        check_eq("nomask_ack_end", cfg_ack, 0);

        // Lock never returns: initial + 2 retries, then ERROR
        repeat (3) @(negedge clk);
        lock_avail = 1'b0;
        e0 = pd_eps;
        wr_addr.delete(); wr_data.delete();
        cfg_div = {7'd0, 7'd5, 7'd0}; cfg_mask = 3'b010; cfg_req = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
        for (int i = 0; i < 1000 && !cfg_err; i++) @(negedge clk);
        @(negedge clk);
        check_eq("retry_err",       cfg_err, 1);
        check_eq("retry_pd_eps",    pd_eps - e0, 3);
        check_eq("retry_wr_count",  wr_addr.size(), 3);
        check_eq("retry_wr_addr",   wr_addr[2], 8'h11);
        check_eq("retry_wr_data",   wr_data[2], 5);
        check_eq("error_busy",      busy, 0);
        check_eq("error_pwrdn",     pwrdn, 0);
        check_eq("error_out_en",    out_en, 0);
        check_eq("error_locked",    locked, 0);

        // Recovery from ERROR with lock available
        lock_avail = 1'b1;
        a0 = ack_cnt;
        cfg_mask = 3'b000; cfg_req = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
        @(negedge clk);
        check_eq("recover_err_sticky", cfg_err, 1);
        check_eq("recover_busy",       busy, 1);
        for (int i = 0; i < 300 && ack_cnt == a0; i++) @(negedge clk);
        @(negedge clk);
        check_eq("recover_ack",    ack_cnt - a0, 1);
        check_eq("recover_err",    cfg_err, 0);
        check_eq("recover_locked", locked, 1);

        // Three 20-cycle lock drops in RUN
        repeat (3) @(negedge clk);
        e0 = pd_eps;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 force_drop = 1'b1;
            repeat (10) @(negedge clk);
            check_eq("lol_out_en", out_en, 0);
            check_eq("lol_locked", locked, 0);
            check_eq("lol_pwrdn",  pwrdn, 1);
            repeat (10) @(negedge clk);
            @(posedge clk); #1 force_drop = 1'b0;
            for (int i = 0; i < 100 && !locked; i++) @(negedge clk);
            check_eq("lol_relock", locked, 1);
            repeat (2) @(negedge clk);
        end
        check_eq("lol_count3", lol_count, 3);
        check_eq("lol_no_pd",  pd_eps - e0, 0);

        // Clear coinciding with the fourth loss-of-lock increment
        @(posedge clk); #1 force_drop = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        lol_clr = 1'b1;
        @(negedge clk);
        lol_clr = 1'b0;
        check_eq("lol_clr_inc",    lol_count, 1);
        check_eq("lol_clr_locked", locked, 0);
        @(posedge clk); #1 force_drop = 1'b0;
        for (int i = 0; i < 100 && !locked; i++) @(negedge clk);
        check_eq("lol_clr_relock", locked, 1);

        // Reset while a DRI write is outstanding
        repeat (3) @(negedge clk);
        hold_ack = 1'b1;
        cfg_div = {7'd0, 7'd0, 7'd3}; cfg_mask = 3'b001; cfg_req = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
        for (int i = 0; i < 100 && !dri_wr; i++) @(negedge clk);
        check_eq("rstwr_wr_held", dri_wr, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check_eq("rstwr_dri_wr", dri_wr, 0);
        check_eq("rstwr_pwrdn",  pwrdn, 0);
        check_eq("rstwr_busy",   busy, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold_ack = 1'b0;
        wr_addr.delete(); wr_data.delete();
        a0 = ack_cnt;
        for (int i = 0; i < 200 && !locked; i++) @(negedge clk);
        check_eq("rstwr_relock", locked, 1);
        check_eq("rstwr_no_wr",  wr_addr.size(), 0);
        check_eq("rstwr_no_ack", ack_cnt - a0, 0);
        check_eq("rstwr_lol",    lol_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
